mem_arbiter: RTL

Two-port round-robin arbiter that shares one single-ported 8-bit data memory between the core's data port (LD/ST/PUSH/POP) and a second requester (DMA/debug loader). It captures the single-cycle read/write strobes each requester issues, serialises them onto a req/ack memory handshake, and returns a one-cycle done pulse with read data to the originating port. It sits between `core` and the RAM model/controller.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-ported 8-bit memory over a req/ack handshake.
// Build option: define MEM_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog and the err outputs.
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [7:0]        i_p0_wdata,
  input  logic              i_p0_read,
  input  logic              i_p0_write,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [7:0]        i_p1_wdata,
  input  logic              i_p1_read,
  input  logic              i_p1_write,
  output logic [7:0]        o_p0_rdata,
  output logic [7:0]        o_p1_rdata,
  output logic              o_p0_done,
  output logic              o_p1_done,
  output logic              o_p0_err,
  output logic              o_p1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_req,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NPORT  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q;
  logic [NPORT-1:0]             pend_q, pend_d;
  logic [NPORT-1:0]             strobe_c, wr_c, accept_c;
  logic [NPORT-1:0][ADDR_W-1:0] addr_in_c;
  logic [NPORT-1:0][DATA_W-1:0] wdata_in_c;
  logic [NPORT-1:0][ADDR_W-1:0] lat_addr_q;
  logic [NPORT-1:0][DATA_W-1:0] lat_wdata_q;
  logic [NPORT-1:0]             lat_we_q;
  logic                         last_q, win_q, grant_c;
  logic [NPORT-1:0][DATA_W-1:0] rdata_q;
  logic [NPORT-1:0]             done_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [DATA_W-1:0]            mem_wdata_q;
  logic                         mem_we_q, mem_req_q;
  logic                         expire_c;

  assign addr_in_c  = {i_p1_addr, i_p0_addr};
  assign wdata_in_c = {i_p1_wdata, i_p0_wdata};
  assign strobe_c   = {i_p1_read | i_p1_write, i_p0_read | i_p0_write};
  assign wr_c       = {i_p1_write, i_p0_write};

  // A strobe is dropped while its port is pending or is the one currently on the bus
  always_comb begin
    accept_c = '0;
    for (int n = 0; n < NPORT; n++) begin
      accept_c[n] = strobe_c[n] && !pend_q[n] && !((state_q == S_BUSY) && (win_q == 1'(n)));
    end
  end

  // Prefer the port that was not served last; otherwise the only one pending
  assign grant_c = pend_q[~last_q] ? ~last_q : last_q;

  always_comb begin
    pend_d = pend_q | accept_c;
    if ((state_q == S_IDLE) && (|pend_q)) begin
      pend_d[grant_c] = 1'b0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic [NPORT-1:0] err_q;
  assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_p0_err = err_q[0];
  assign o_p1_err = err_q[1];
`else
  // Watchdog compiled out: TIMEOUT_CYCLES is accepted but never expires
  assign expire_c = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
  assign o_p0_err = 1'b0;
  assign o_p1_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_we_q    <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      pend_q <= pend_d;
      done_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q  <= '0;
`endif
      for (int n = 0; n < NPORT; n++) begin
        if (accept_c[n]) begin
          lat_addr_q[n]  <= addr_in_c[n];
          lat_wdata_q[n] <= wdata_in_c[n];
          lat_we_q[n]    <= wr_c[n];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (|pend_q) begin
            win_q       <= grant_c;
            last_q      <= grant_c;
            mem_addr_q  <= lat_addr_q[grant_c];
            mem_wdata_q <= lat_wdata_q[grant_c];
            mem_we_q    <= lat_we_q[grant_c];
            mem_req_q   <= 1'b1;
            state_q     <= S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        S_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
`endif
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              rdata_q[win_q] <= i_mem_rdata;
            end
            done_q[win_q] <= 1'b1;
            state_q       <= S_DONE;
          end else if (expire_c) begin
            mem_req_q      <= 1'b0;
            rdata_q[win_q] <= 8'hFF;
            done_q[win_q]  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q[win_q]   <= 1'b1;
`endif
            state_q        <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_p0_rdata  = rdata_q[0];
  assign o_p1_rdata  = rdata_q[1];
  assign o_p0_done   = done_q[0];
  assign o_p1_done   = done_q[1];
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_req   = mem_req_q;
  assign o_busy      = (state_q == S_BUSY) || (|pend_q);

endmodule
